// File: rtl/pipe_pkg.sv
// Shared pipeline constants for stage registers.
//   NOP_INSTR : encoding injected into a stage when it holds no real entry
//   IF_ID_W   : payload width of the IF/ID register (npc[31:0] ++ instr[31:0])
package pipe_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          IF_ID_W   = 64;
endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with flush and stall counter.
// in_ready comes straight from a register, so there is no combinational
// path from out_ready back upstream.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   flush          : squash every held entry and any same-cycle input
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//   stall_cnt      : saturating count of cycles with out_valid & ~out_ready
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = IF_ID_W,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_vld, skid_vld;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_hs, out_hs;
  // Payload load enables; valid bits are handled separately.
  logic              main_ld_in, main_ld_skid, skid_ld;

  assign in_ready  = ~skid_vld;
  assign out_valid = main_vld;
  assign out_data  = main_vld ? main_q : NOP_VAL;

  assign in_hs  = in_valid & ~skid_vld;
  assign out_hs = main_vld & out_ready;

  // Skid is only ever full while main is full, so main empty implies skid empty.
  always_comb begin
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (!main_vld)     main_ld_in   = in_hs;
    else if (out_hs) begin
      main_ld_skid = skid_vld;
      main_ld_in   = ~skid_vld & in_hs;
    end else           skid_ld      = in_hs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld  <= 1'b0;
      skid_vld  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      // Counts through flush cycles too; holds at all-ones.
      if (main_vld && !out_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) begin
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
      end else if (!main_vld) begin
        main_vld <= in_hs;
      end else if (out_hs) begin
        // Skid refills main first; its slot frees (in_ready was 0 this cycle).
        main_vld <= skid_vld | in_hs;
        skid_vld <= 1'b0;
      end else if (in_hs) begin
        skid_vld <= 1'b1;
      end
    end
  end

  // Payload carries no reset; stale contents are masked by the valid bits.
  always_ff @(posedge clk) begin
    if (main_ld_skid)    main_q <= skid_q;
    else if (main_ld_in) main_q <= in_data;
    if (skid_ld)         skid_q <= in_data;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set payload width (e.g. npc[31:0] concatenated with instr[31:0]).
REQ-002 Parameter NOP_VAL, default {DATA_W{1'b0}}, SHALL set the value driven on out_data whenever out_valid is 0; a zero instruction is a MIPS nop.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its posedge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 flush  input  1  SHALL discard all held entries (branch/jump squash).
REQ-007 in_valid  input  1  SHALL indicate that in_data is offered.
REQ-008 in_ready  output  1  SHALL indicate the stage accepts in_data this cycle.
REQ-009 in_data  input  DATA_W  SHALL carry the upstream payload.
REQ-010 out_valid  output  1  SHALL indicate that out_data holds a real entry.
REQ-011 out_ready  input  1  SHALL indicate that downstream consumes out_data this cycle.
REQ-012 out_data  output  DATA_W  SHALL carry the downstream payload.
REQ-013 stall_cnt  output  CNT_W  SHALL count cycles with out_valid=1 and out_ready=0.

Function
REQ-014 The stage SHALL hold two entries: main (drives out_*) and skid; each has a valid bit.
REQ-015 An input handshake SHALL occur when in_valid and in_ready are both 1; an output handshake SHALL occur when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL equal NOT skid_valid, taken directly from a register with no combinational path from out_ready.
REQ-017 Main empty and input handshake: in_data SHALL load main; out_valid is 1 on the next cycle (latency 1).
REQ-018 Main full and output handshake: main SHALL load skid if skid is valid, else in_data if an input handshake occurs, else become empty.
REQ-019 Main full, no output handshake, input handshake: in_data SHALL load skid.
REQ-020 Main and skid both full: in_ready SHALL be 0 and no entry is lost.
REQ-021 Entries SHALL leave in arrival order; sustained throughput SHALL be one entry per cycle when out_ready is held at 1.
REQ-022 out_data SHALL equal NOP_VAL whenever out_valid is 0.
REQ-023 flush=1 SHALL clear main_valid and skid_valid at the next edge; an input handshake in the same cycle SHALL be dropped; flush takes priority over all loads.
REQ-024 An output handshake in a flush cycle SHALL still count as consumed by downstream.
REQ-025 stall_cnt SHALL increment by 1 per stall cycle, saturate at all-ones, and be unaffected by flush.

Reset
REQ-026 rst=1 at a posedge SHALL clear main_valid, skid_valid and stall_cnt to 0.
REQ-027 After reset, out_valid SHALL be 0, out_data SHALL be NOP_VAL and in_ready SHALL be 1.
REQ-028 rst SHALL take priority over flush and all handshakes, including when asserted mid-stall with both entries full.
REQ-029 Payload registers SHALL NOT require a reset value.

Structure
REQ-030 A shared package pipe_pkg SHALL define NOP_INSTR (32'h0000_0000) and IF_ID_W (64) for instantiation as the IF/ID register.
REQ-031 The block SHALL be a single module with no sub-modules; skid logic is inline.

Verification
REQ-032 Reset then stream: in_data 1,2,3 on consecutive cycles with out_ready=1 -> out_data 1,2,3 on the following three cycles, out_valid=1 throughout, in_ready=1 throughout.
REQ-033 Backpressure: out_ready=0 while sending A,B -> in_ready=0 after B; raise out_ready -> A then B appear, then in_ready=1; stall_cnt equals the number of stalled cycles.
REQ-034 Flush with both entries full, plus in_valid=1 with C in the same cycle -> next cycle out_valid=0, out_data=NOP_VAL, C never appears.
REQ-035 Reset mid-operation: rst=1 with both entries full and stall_cnt=5 -> next cycle out_valid=0, in_ready=1, stall_cnt=0.
REQ-036 Saturation: CNT_W=4, hold 20 stall cycles -> stall_cnt=15 and it stays at 15.
REQ-037 Randomised valid/ready over 10k cycles -> scoreboard shows every accepted entry not flushed exits once, in order, with none lost or duplicated.
